// File: rtl/dot_matrix_frame_scanner.sv
// Double-buffered 8x8 LED frame store with a row scanner.
// Upstream writes rows into the back bank; the front bank is scanned and the banks swap only at a frame boundary.
module dot_matrix_frame_scanner #(
    parameter int SCAN_DIV     = 5000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic       wr_last,
    output logic [7:0] dot_row,
    output logic [7:0] dot_col,
    output logic       frame_tick,
    output logic       swap_pending
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] prescaler_reg, prescaler_next;
    logic [2:0]    row_idx_reg, row_idx_next;
    logic          front_sel_reg, front_sel_next;
    logic          swap_pending_reg, swap_pending_next;
    logic          wr_ready_reg, wr_ready_next;
    logic          frame_tick_reg;
    logic [7:0]    dot_row_reg;
    logic [7:0]    dot_col_reg;
    logic [7:0]    bank_reg [2][8];

    logic          slot_end;
    logic          frame_end;
    logic          swap;
    logic          accept;
    logic          blank;
    logic [7:0]    row_sel;

    assign slot_end  = (prescaler_reg == PW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (row_idx_reg == 3'd7);
    assign swap      = frame_end && swap_pending_reg;
    assign accept    = wr_valid && wr_ready_reg;

    // Blanking window at the start of every row slot; compare is elided when there is no window.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign blank = 1'b0;
        end else begin : g_blank
            assign blank = (prescaler_reg < PW'(BLANK_CYCLES));
        end
    endgenerate

    // One-cold row select: row 0 drives bit 7 low.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_row_sel
            assign row_sel[gi] = (row_idx_reg != 3'(7 - gi));
        end
    endgenerate

    always_comb begin
        prescaler_next    = slot_end ? '0 : prescaler_reg + PW'(1);
        row_idx_next      = slot_end ? row_idx_reg + 3'd1 : row_idx_reg;
        front_sel_next    = swap ? ~front_sel_reg : front_sel_reg;
        swap_pending_next = swap_pending_reg;
        // A commit landing on the swap edge cannot also swap there: swap needs the registered flag.
        if (accept && wr_last) begin
            swap_pending_next = 1'b1;
        end else if (swap) begin
            swap_pending_next = 1'b0;
        end
        wr_ready_next = ~swap_pending_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler_reg    <= '0;
            row_idx_reg      <= 3'd0;
            front_sel_reg    <= 1'b0;
            swap_pending_reg <= 1'b0;
            wr_ready_reg     <= 1'b0;
            frame_tick_reg   <= 1'b0;
            dot_row_reg      <= 8'hFF;
            dot_col_reg      <= 8'h00;
        end else begin
            prescaler_reg    <= prescaler_next;
            row_idx_reg      <= row_idx_next;
            front_sel_reg    <= front_sel_next;
            swap_pending_reg <= swap_pending_next;
            wr_ready_reg     <= wr_ready_next;
            frame_tick_reg   <= frame_end;
            dot_row_reg      <= blank ? 8'hFF : row_sel;
            dot_col_reg      <= blank ? 8'h00 : bank_reg[front_sel_reg][row_idx_reg];
        end
    end

    // Both banks clear on reset, so the banks live in flops rather than block RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 8; r++) begin
                    bank_reg[b][r] <= 8'h00;
                end
            end
        end else if (accept) begin
            bank_reg[~front_sel_reg][wr_row] <= wr_data;
        end
    end

    assign wr_ready     = wr_ready_reg;
    assign swap_pending = swap_pending_reg;
    assign frame_tick   = frame_tick_reg;
    assign dot_row      = dot_row_reg;
    assign dot_col      = dot_col_reg;

endmodule

// File: tb/tb_dot_matrix_frame_scanner.sv
// Bench for dot_matrix_frame_scanner with SCAN_DIV=4, BLANK_CYCLES=1 (32-cycle frame).
// Expected scan output for each frame is queued from a bench-held frame image and popped per cycle.
module tb_dot_matrix_frame_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [2:0] wr_row = 3'd0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_last = 1'b0;
    logic [7:0] dot_row;
    logic [7:0] dot_col;
    logic       frame_tick;
    logic       swap_pending;

    int checks = 0;
    int passes = 0;
    int edge_cnt = 0;

    typedef struct {
        logic [7:0] row;
        logic [7:0] col;
        logic       tick;
    } exp_t;
    exp_t sb_q[$];

    logic [7:0] zero_frame [8];
    logic [7:0] walk_frame [8];
    logic [7:0] aa_frame   [8];
    logic [7:0] rw_frame   [8];
    logic [7:0] f0_frame   [8];

    dot_matrix_frame_scanner #(.SCAN_DIV(4), .BLANK_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_row(wr_row), .wr_data(wr_data), .wr_last(wr_last),
        .dot_row(dot_row), .dot_col(dot_col), .frame_tick(frame_tick),
        .swap_pending(swap_pending)
    );

    always #5 clk = ~clk;

    // Bench-side timebase: posedges since reset release, used to hit exact scan phases.
    always @(posedge clk or negedge reset) begin
        if (!reset) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic write_beat(input logic [2:0] row, input logic [7:0] data, input logic last);
        checks++;
        if (wr_ready !== 1'b1) $display("FAIL ready_before_write: wr_ready=%b expected 1", wr_ready);
        else passes++;
        wr_valid = 1'b1; wr_row = row; wr_data = data; wr_last = last;
        $display("write row=%0d data=%h last=%b", row, data, last);
        @(negedge clk);
        wr_valid = 1'b0; wr_last = 1'b0;
    endtask

    task automatic wait_tick(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 80);
        checks++;
        if (frame_tick !== 1'b1) $display("FAIL %s tick_timeout: frame_tick=%b expected 1", name, frame_tick);
        else passes++;
    endtask

    task automatic wait_phase(input int phase);
        int n = 0;
        while ((edge_cnt % 32) != phase && n < 80) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((edge_cnt % 32) != phase) $display("FAIL phase_timeout: phase=%0d expected %0d", edge_cnt % 32, phase);
        else passes++;
    endtask

    // Called on the negedge of a frame_tick cycle; covers the following 32 cycles.
    task automatic scan_frame(input string name, input logic [7:0] rows [8]);
        exp_t e;
        int k;
        for (int c = 1; c <= 32; c++) begin
            e.tick = (c == 32);
            if ((c - 1) % 4 == 0) begin
                e.row = 8'hFF;
                e.col = 8'h00;
            end else begin
                e.row = ~(8'h80 >> ((c - 1) / 4));
                e.col = rows[(c - 1) / 4];
            end
            sb_q.push_back(e);
        end
        k = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            k++;
            e = sb_q.pop_front();
            checks++;
            if (dot_row !== e.row || dot_col !== e.col || frame_tick !== e.tick)
                $display("FAIL %s scan cycle %0d: row=%h col=%h tick=%b expected row=%h col=%h tick=%b",
                         name, k, dot_row, dot_col, frame_tick, e.row, e.col, e.tick);
            else passes++;
        end
        $display("scan frame %s done", name);
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dot_row !== 8'hFF || dot_col !== 8'h00 || wr_ready !== 1'b0 || swap_pending !== 1'b0 || frame_tick !== 1'b0)
            $display("FAIL reset_state: row=%h col=%h rdy=%b pend=%b tick=%b expected FF 00 0 0 0",
                     dot_row, dot_col, wr_ready, swap_pending, frame_tick);
        else passes++;
        reset = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b0) $display("FAIL ready_at_release: wr_ready=%b expected 0", wr_ready);
        else passes++;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1) $display("FAIL ready_after_edge: wr_ready=%b expected 1", wr_ready);
        else passes++;
        wait_tick("reset");
        scan_frame("reset_a", zero_frame);
        scan_frame("reset_b", zero_frame);
    endtask

    task automatic test_walking_frame();
        for (int r = 0; r < 8; r++) write_beat(3'(r), walk_frame[r], r == 7);
        checks++;
        if (swap_pending !== 1'b1 || wr_ready !== 1'b0)
            $display("FAIL walk_commit: pend=%b rdy=%b expected 1 0", swap_pending, wr_ready);
        else passes++;
        wait_tick("walk");
        checks++;
        if (swap_pending !== 1'b0 || wr_ready !== 1'b1)
            $display("FAIL walk_swap: pend=%b rdy=%b expected 0 1", swap_pending, wr_ready);
        else passes++;
        scan_frame("walk", walk_frame);
    endtask

    task automatic test_hold_valid();
        for (int r = 0; r < 8; r++) write_beat(3'(r), 8'hAA, r == 7);
        checks++;
        if (swap_pending !== 1'b1 || wr_ready !== 1'b0)
            $display("FAIL hold_commit: pend=%b rdy=%b expected 1 0", swap_pending, wr_ready);
        else passes++;
        wr_valid = 1'b1; wr_row = 3'd0; wr_data = 8'h55; wr_last = 1'b1;
        wait_tick("hold");
        wr_valid = 1'b0; wr_last = 1'b0;
        checks++;
        if (swap_pending !== 1'b0 || wr_ready !== 1'b1)
            $display("FAIL hold_swap: pend=%b rdy=%b expected 0 1", swap_pending, wr_ready);
        else passes++;
        scan_frame("hold", aa_frame);
    endtask

    task automatic test_rewrite();
        write_beat(3'd2, 8'h3C, 1'b0);
        write_beat(3'd2, 8'hC3, 1'b1);
        wait_tick("rewrite");
        scan_frame("rewrite", rw_frame);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 7; r++) write_beat(3'(r), f0_frame[r], 1'b0);
        wait_phase(31);
        checks++;
        if (swap_pending !== 1'b0 || wr_ready !== 1'b1)
            $display("FAIL simul_pre: pend=%b rdy=%b expected 0 1", swap_pending, wr_ready);
        else passes++;
        write_beat(3'd7, f0_frame[7], 1'b1);
        checks++;
        if (frame_tick !== 1'b1 || swap_pending !== 1'b1 || wr_ready !== 1'b0)
            $display("FAIL simul_edge: tick=%b pend=%b rdy=%b expected 1 1 0", frame_tick, swap_pending, wr_ready);
        else passes++;
        scan_frame("simul_old", rw_frame);
        checks++;
        if (swap_pending !== 1'b0 || wr_ready !== 1'b1)
            $display("FAIL simul_swap: pend=%b rdy=%b expected 0 1", swap_pending, wr_ready);
        else passes++;
        scan_frame("simul_new", f0_frame);
    endtask

    task automatic test_reset_mid_frame();
        for (int r = 0; r < 8; r++) write_beat(3'(r), 8'hFF, r == 7);
        wait_phase(14);
        checks++;
        if (swap_pending !== 1'b1 || dot_row !== 8'hEF || dot_col !== 8'hF3)
            $display("FAIL mid_pre: pend=%b row=%h col=%h expected 1 EF F3", swap_pending, dot_row, dot_col);
        else passes++;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (dot_row !== 8'hFF || dot_col !== 8'h00 || swap_pending !== 1'b0 || wr_ready !== 1'b0 || frame_tick !== 1'b0)
            $display("FAIL mid_reset: row=%h col=%h pend=%b rdy=%b tick=%b expected FF 00 0 0 0",
                     dot_row, dot_col, swap_pending, wr_ready, frame_tick);
        else passes++;
        @(negedge clk);
        reset = 1'b1;
        wait_tick("mid");
        checks++;
        if (swap_pending !== 1'b0) $display("FAIL mid_pending: pend=%b expected 0", swap_pending);
        else passes++;
        scan_frame("mid", zero_frame);
    endtask

    initial begin
        for (int r = 0; r < 8; r++) begin
            zero_frame[r] = 8'h00;
            walk_frame[r] = 8'h01 << r;
            aa_frame[r]   = 8'hAA;
            rw_frame[r]   = 8'h01 << r;
            f0_frame[r]   = 8'hF0 | 8'(r);
        end
        rw_frame[2] = 8'hC3;
        test_reset();
        test_walking_frame();
        test_hold_valid();
        test_rewrite();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
